att_token_feeder: RTL and testbench

- Upstream producer for the attention core: reads an HW-token activation/bias sequence from the feature buffer and streams it into the core as `i_att`/`att_bias`, with `en` framing.
- Replays the token sequence PASSES times, one pass per core phase (pass 0 builds K/Q, pass 1 builds V).
- Inserts one idle cycle between passes so the core's token counter clears.
- Honours a stall from the core side and reports busy/done to the layer controller.

---
 rtl/att_token_feeder.sv | 178 +++++++++++++++++
 tb/tb_att_token_feeder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/att_token_feeder.sv
// rtl/att_token_feeder.sv - replays an HW-token activation/bias sequence into the attention core
`timescale 1ns/1ps
module att_token_feeder #(
    parameter int ATT_WIDTH = 8,
    parameter int HW        = 16,
    parameter int PASSES    = 2,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 act_rd,
    output logic [ADDR_W-1:0]    act_addr,
    input  logic [ATT_WIDTH-1:0] act_rdata,
    input  logic [ATT_WIDTH-1:0] bias_rdata,
    input  logic                 att_stall,
    output logic                 att_en,
    output logic [ATT_WIDTH-1:0] i_att,
    output logic [ATT_WIDTH-1:0] att_bias,
    output logic                 att_last
);

    localparam int TOK_W  = $clog2(HW);
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    typedef enum logic [2:0] {IDLE, RUN, GAP, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [TOK_W-1:0]      tok_q, tok_d;
    logic [PASS_W-1:0]     pass_q, pass_d;
    logic [ADDR_W-1:0]     base_q, base_d;

    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;

    logic                  skid_valid_q, skid_valid_d;
    logic [ATT_WIDTH-1:0]  skid_act_q, skid_act_d;
    logic [ATT_WIDTH-1:0]  skid_bias_q, skid_bias_d;
    logic                  skid_last_q, skid_last_d;

    logic                  att_en_q, att_en_d;
    logic [ATT_WIDTH-1:0]  i_att_q, i_att_d;
    logic [ATT_WIDTH-1:0]  att_bias_q, att_bias_d;
    logic                  att_last_q, att_last_d;

    logic                  rd_issue;
    logic                  tok_last;

    // A read is only issued when the returning word is guaranteed a home:
    // not stalled now (output stage will drain) and the skid is free.
    assign rd_issue = (state_q == RUN) && !att_stall && !skid_valid_q;
    assign tok_last = (tok_q == TOK_W'(HW - 1));

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        pass_d  = pass_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    base_d  = base_addr;
                    tok_d   = '0;
                    pass_d  = '0;
                end
            end
            RUN: begin
                if (rd_issue) begin
                    tok_d = tok_last ? '0 : tok_q + TOK_W'(1);
                    if (tok_last) begin
                        state_d = (pass_q == PASS_W'(PASSES - 1)) ? FLUSH : GAP;
                    end
                end
            end
            GAP: begin
                pass_d  = pass_q + PASS_W'(1);
                tok_d   = '0;
                state_d = RUN;
            end
            FLUSH: begin
                // Last token is either already gone or leaves the output stage this cycle.
                if (!skid_valid_q && !rd_valid_q && (!att_en_q || !att_stall)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_valid_d   = rd_issue;
        rd_last_d    = rd_issue && tok_last;
        skid_valid_d = skid_valid_q;
        skid_act_d   = skid_act_q;
        skid_bias_d  = skid_bias_q;
        skid_last_d  = skid_last_q;
        att_en_d     = att_en_q;
        i_att_d      = i_att_q;
        att_bias_d   = att_bias_q;
        att_last_d   = att_last_q;
        if (!att_stall) begin
            if (skid_valid_q) begin
                att_en_d     = 1'b1;
                i_att_d      = skid_act_q;
                att_bias_d   = skid_bias_q;
                att_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (rd_valid_q) begin
                att_en_d   = 1'b1;
                i_att_d    = act_rdata;
                att_bias_d = bias_rdata;
                att_last_d = rd_last_q;
            end else begin
                att_en_d   = 1'b0;
                att_last_d = 1'b0;
            end
        end else if (rd_valid_q) begin
            // Skid is always empty here: a read is never issued while it is full.
            skid_valid_d = 1'b1;
            skid_act_d   = act_rdata;
            skid_bias_d  = bias_rdata;
            skid_last_d  = rd_last_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            tok_q        <= '0;
            pass_q       <= '0;
            base_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_act_q   <= '0;
            skid_bias_q  <= '0;
            skid_last_q  <= 1'b0;
            att_en_q     <= 1'b0;
            i_att_q      <= '0;
            att_bias_q   <= '0;
            att_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tok_q        <= tok_d;
            pass_q       <= pass_d;
            base_q       <= base_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            skid_valid_q <= skid_valid_d;
            skid_act_q   <= skid_act_d;
            skid_bias_q  <= skid_bias_d;
            skid_last_q  <= skid_last_d;
            att_en_q     <= att_en_d;
            i_att_q      <= i_att_d;
            att_bias_q   <= att_bias_d;
            att_last_q   <= att_last_d;
        end
    end

    assign act_rd   = rd_issue;
    assign act_addr = base_q + ADDR_W'(tok_q);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign att_en   = att_en_q;
    assign i_att    = i_att_q;
    assign att_bias = att_bias_q;
    assign att_last = att_last_q;

endmodule

// File: tb/tb_att_token_feeder.sv
// tb/tb_att_token_feeder.sv - scoreboard bench for att_token_feeder
`timescale 1ns/1ps
module tb_att_token_feeder;

    localparam int AW     = 8;
    localparam int HW     = 16;
    localparam int PASSES = 2;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy, done, act_rd;
    logic [ADDR_W-1:0] act_addr;
    logic [AW-1:0]     act_rdata = '0;
    logic [AW-1:0]     bias_rdata = '0;
    logic              att_stall = 1'b0;
    logic              att_en, att_last;
    logic [AW-1:0]     i_att, att_bias;

    att_token_feeder #(.ATT_WIDTH(AW), .HW(HW), .PASSES(PASSES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .act_rd(act_rd), .act_addr(act_addr),
        .act_rdata(act_rdata), .bias_rdata(bias_rdata), .att_stall(att_stall),
        .att_en(att_en), .i_att(i_att), .att_bias(att_bias), .att_last(att_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          l;
    } tok_t;

    tok_t              exp_tok[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [AW-1:0]     act_mem[1024];
    logic [AW-1:0]     bias_mem[1024];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    bit idle_chk = 0, seq_chk = 0, end_chk = 0, rst_chk = 0, tmo = 0;
    bit en_exp = 0, done_exp = 0, busy_exp = 0;
    int runs_exp = 0;
    int xfer_exp = 0;
    int stall_mode = 0;

    // Feature buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (act_rd) begin
            act_rdata  <= act_mem[act_addr];
            bias_rdata <= bias_mem[act_addr];
        end
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        tok_t              et;
        logic [ADDR_W-1:0] ea;
        if (!rstn) begin
            exp_tok.delete();
            exp_addr.delete();
            xfer_cnt = 0;
            if (rst_chk) begin
                chk({busy, done, act_rd, att_en, att_last, i_att, att_bias, act_addr} == '0,
                    "reset_outputs", {busy, done, act_rd, att_en, att_last, i_att, att_bias, act_addr}, 0);
            end
        end else begin
            if (idle_chk) begin
                chk({busy, done, act_rd, att_en, att_last, i_att, att_bias} == '0,
                    "idle_outputs", {busy, done, act_rd, att_en, att_last, i_att, att_bias}, 0);
            end
            if (seq_chk) begin
                chk(att_en == en_exp, "en_timing", att_en, en_exp);
                chk(done == done_exp, "done_timing", done, done_exp);
                chk(busy == busy_exp, "busy_timing", busy, busy_exp);
            end
            if (act_rd) begin
                chk(!att_stall, "rd_while_stall", att_stall, 0);
                if (exp_addr.size() == 0) begin
                    chk(0, "unexpected_read", act_addr, 0);
                end else begin
                    ea = exp_addr.pop_front();
                    chk(act_addr == ea, "read_addr", act_addr, ea);
                end
            end
            if (att_en && !att_stall) begin
                xfer_cnt++;
                if (exp_tok.size() == 0) begin
                    chk(0, "unexpected_token", {i_att, att_bias, att_last}, 0);
                end else begin
                    et = exp_tok.pop_front();
                    chk({i_att, att_bias, att_last} == et, "token", {i_att, att_bias, att_last}, et);
                end
            end
            if (done) begin
                done_cnt++;
                chk(done_cnt <= runs_exp && exp_tok.size() == 0 && exp_addr.size() == 0,
                    "done_early", done_cnt, runs_exp);
            end
            if (end_chk) begin
                chk(done_cnt == runs_exp, "done_count", done_cnt, runs_exp);
                chk(xfer_cnt == xfer_exp, "xfer_count", xfer_cnt, xfer_exp);
                chk(busy == 1'b0, "busy_after_run", busy, 0);
                chk(exp_tok.size() == 0, "tokens_left", exp_tok.size(), 0);
            end
            if (tmo) chk(0, "timeout_wait_done", 0, 1);
        end
    end

    // Stall generator: ~40% random, plus 5-cycle bursts right after a read.
    always begin
        bit rd_seen;
        int burst;
        int nreads;
        @(negedge clk);
        rd_seen = act_rd;
        @(posedge clk);
        #1;
        if (stall_mode == 0) begin
            att_stall = 1'b0;
            burst = 0;
            nreads = 0;
        end else if (burst > 0) begin
            att_stall = 1'b1;
            burst--;
        end else if (rd_seen && (nreads == 2 || $urandom_range(0, 19) == 0)) begin
            att_stall = 1'b1;
            burst = 4;
            nreads++;
        end else begin
            att_stall = ($urandom_range(0, 99) < 40);
            if (rd_seen) nreads++;
        end
    end

    task automatic fill_nominal();
        for (int i = 0; i < 1024; i++) begin
            act_mem[i]  = i[7:0];
            bias_mem[i] = ~i[7:0];
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) begin
            act_mem[i]  = 8'($urandom);
            bias_mem[i] = 8'($urandom);
        end
    endtask

    task automatic push_run(input logic [ADDR_W-1:0] b, input bit completes);
        logic [ADDR_W-1:0] a;
        for (int p = 0; p < PASSES; p++) begin
            for (int t = 0; t < HW; t++) begin
                a = b + ADDR_W'(t);
                exp_addr.push_back(a);
                exp_tok.push_back({act_mem[a], bias_mem[a], (t == HW - 1)});
            end
        end
        if (completes) begin
            runs_exp++;
            xfer_exp += HW * PASSES;
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic end_check();
        end_chk = 1;
        cycle();
        end_chk = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            cycle();
            n++;
        end
        if (n >= 3000) begin
            tmo = 1;
            cycle();
            tmo = 0;
        end
        cycle();
    endtask

    // Unstalled run with cycle-exact expectations relative to the start cycle T.
    task automatic nominal_run(input logic [ADDR_W-1:0] b);
        push_run(b, 1'b1);
        do_start(b);
        for (int i = 1; i <= 40; i++) begin
            en_exp   = (i >= 3 && i <= 18) || (i >= 20 && i <= 35);
            done_exp = (i == 36);
            busy_exp = (i <= 36);
            seq_chk  = 1;
            cycle();
        end
        seq_chk = 0;
        end_check();
    endtask

    initial begin
        #3 rstn = 1'b0;
        rst_chk = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_chk = 0;
        rstn = 1'b1;

        idle_chk = 1;
        repeat (10) cycle();
        idle_chk = 0;

        fill_nominal();
        nominal_run(10'h100);

        stall_mode = 1;
        push_run(10'h100, 1'b1);
        do_start(10'h100);
        wait_done();
        end_check();

        fill_random();
        push_run(10'h3F8, 1'b1);
        do_start(10'h3F8);
        wait_done();
        end_check();

        push_run(10'h055, 1'b1);
        do_start(10'h055);
        repeat (12) cycle();
        do_start(10'h200);
        wait_done();
        end_check();

        stall_mode = 0;
        repeat (3) cycle();
        fill_nominal();
        push_run(10'h100, 1'b0);
        do_start(10'h100);
        repeat (9) @(posedge clk);
        #2;
        rstn = 1'b0;
        rst_chk = 1;
        xfer_exp = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_chk = 0;
        rstn = 1'b1;
        cycle();
        nominal_run(10'h100);

        repeat (3) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
